// File: rtl/synchronous_fifo_pkg.sv
// Shared sizing helpers and output-mode constants for the flexible FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package synchronous_fifo_pkg;

    localparam int FIFO_MODE_REGISTERED = 0;
    localparam int FIFO_MODE_FWFT       = 1;

    // Address width needed to index every entry.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_memory_dual_port.sv
// Storage array: one synchronous write port, one asynchronous-address read port, no reset.
// Latency: write visible on the read port after the write edge; read is combinational from address.
// Backpressure: none; the caller gates write_enable.
// Ports: clock, write_enable/write_address/write_data (write port), read_address/read_data (read port).
module fifo_memory_dual_port #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/synchronous_fifo_flex.sv
// Single-clock FIFO, any depth >= 2, with count, almost flags, sticky errors, registered or FWFT output.
// Latency: flags/count 1 edge after write; mode 0 data 1 edge after pop; mode 1 head valid 1 edge after write.
// Backpressure: writes while full without a same-cycle pop are dropped (overflow); reads while empty are ignored (underflow).
// Ports: clock, reset (sync, active-high); write_enable/write_data; read_enable/read_data/read_data_valid;
//        full, empty, almost_full, almost_empty, count, overflow, underflow.
module synchronous_fifo_flex
    import synchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH             = 16,
    parameter int DATA_DEPTH             = 4096,
    parameter int FWFT                   = 0,
    parameter int ALMOST_FULL_THRESHOLD  = DATA_DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 write_enable,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 read_enable,
    output logic [DATA_WIDTH-1:0]                read_data,
    output logic                                 read_data_valid,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic [count_width(DATA_DEPTH)-1:0]   count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int PW = ptr_width(DATA_DEPTH);
    localparam int CW = count_width(DATA_DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DATA_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] AF_T     = CW'(ALMOST_FULL_THRESHOLD);
    localparam logic [CW-1:0] AE_T     = CW'(ALMOST_EMPTY_THRESHOLD);

    logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_next, mem_rd_addr;
    logic [CW-1:0]         count_next, count_after_pop;
    logic [DATA_WIDTH-1:0] mem_rd_data, head_next;
    logic                  push, pop, bypass;

    // Depth need not be a power of two, so wrap explicitly at the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop             = read_enable && !empty;
        push            = write_enable && (!full || pop);
        rd_ptr_next     = pop ? ptr_inc(rd_ptr) : rd_ptr;
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        // In FWFT mode the incoming word becomes the head when nothing else
        // remains after this cycle's pop; it is not in the array yet.
        bypass          = push && (count_after_pop == '0);
        head_next       = bypass ? write_data : mem_rd_data;
    end

    // Registered mode reads the current head; FWFT prefetches the next head.
    assign mem_rd_addr = (FWFT == FIFO_MODE_FWFT) ? rd_ptr_next : rd_ptr;

    fifo_memory_dual_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (PW)
    ) u_mem (
        .clock         (clock),
        .write_enable  (push),
        .write_address (wr_ptr),
        .write_data    (write_data),
        .read_address  (mem_rd_addr),
        .read_data     (mem_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            full            <= 1'b0;
            empty           <= 1'b1;
            almost_full     <= (AF_T == '0);
            almost_empty    <= 1'b1;    // 0 <= any unsigned threshold
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_T);
            almost_empty <= (count_next <= AE_T);
            if (write_enable && full && !pop) begin
                overflow <= 1'b1;
            end
            if (read_enable && empty) begin
                underflow <= 1'b1;
            end
            if (FWFT == FIFO_MODE_FWFT) begin
                read_data_valid <= (count_next != '0);
                if (count_next != '0) begin
                    read_data <= head_next;
                end
            end else begin
                read_data_valid <= pop;
                if (pop) begin
                    read_data <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_synchronous_fifo_flex.sv
// Directed bench: depth-5 registered-read FIFO (A) and depth-4 FWFT FIFO (B).
// Latency: n/a.
// Backpressure: n/a.
module tb_synchronous_fifo_flex;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: depth 5, registered read, AF=3, AE=1
    logic       a_we, a_re, a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [7:0] a_wd, a_rd;
    logic [2:0] a_cnt;
    // Instance B: depth 4, FWFT
    logic       b_we, b_re, b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [7:0] b_wd, b_rd;
    logic [2:0] b_cnt;

    int total = 0;
    int bad   = 0;

    synchronous_fifo_flex #(
        .DATA_WIDTH(8), .DATA_DEPTH(5), .FWFT(0),
        .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)
    ) dut_a (
        .clock(clock), .reset(reset),
        .write_enable(a_we), .write_data(a_wd), .read_enable(a_re),
        .read_data(a_rd), .read_data_valid(a_rv),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_cnt), .overflow(a_ov), .underflow(a_un)
    );

    synchronous_fifo_flex #(
        .DATA_WIDTH(8), .DATA_DEPTH(4), .FWFT(1),
        .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)
    ) dut_b (
        .clock(clock), .reset(reset),
        .write_enable(b_we), .write_data(b_wd), .read_enable(b_re),
        .read_data(b_rd), .read_data_valid(b_rv),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_cnt), .overflow(b_ov), .underflow(b_un)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        a_we = 0; a_re = 0; a_wd = 0;
        b_we = 0; b_re = 0; b_wd = 0;
        tick(); tick();
        // ---------------- reset state ----------------
        chk("rst_a_rd", a_rd, 0);      chk("rst_a_rv", a_rv, 0);
        chk("rst_a_full", a_full, 0);  chk("rst_a_empty", a_empty, 1);
        chk("rst_a_cnt", a_cnt, 0);    chk("rst_a_ov", a_ov, 0);
        chk("rst_a_un", a_un, 0);      chk("rst_a_af", a_af, 0);
        chk("rst_a_ae", a_ae, 1);
        chk("rst_b_rd", b_rd, 0);      chk("rst_b_rv", b_rv, 0);
        chk("rst_b_empty", b_empty, 1);
        reset = 0;

        // ---------------- A: fill 1..5, thresholds ----------------
        for (int i = 1; i <= 5; i++) begin
            a_we = 1; a_wd = 8'(i);
            tick();
            chk($sformatf("fill_cnt%0d", i), a_cnt, i);
            chk($sformatf("fill_af%0d", i), a_af, (i >= 3) ? 1 : 0);
            chk($sformatf("fill_ae%0d", i), a_ae, (i <= 1) ? 1 : 0);
            chk($sformatf("fill_full%0d", i), a_full, (i == 5) ? 1 : 0);
            chk($sformatf("fill_empty%0d", i), a_empty, 0);
        end

        // Full, read+write together: pop 1, push 6, no overflow
        a_we = 1; a_wd = 8'd6; a_re = 1;
        tick();
        chk("fullboth_cnt", a_cnt, 5);  chk("fullboth_full", a_full, 1);
        chk("fullboth_ov", a_ov, 0);    chk("fullboth_rd", a_rd, 1);
        chk("fullboth_rv", a_rv, 1);

        // Full, write alone: rejected, overflow sticks
        a_we = 1; a_wd = 8'hEE; a_re = 0;
        tick();
        chk("ovf_ov", a_ov, 1);   chk("ovf_cnt", a_cnt, 5);
        chk("ovf_rv", a_rv, 0);   chk("ovf_rd_hold", a_rd, 1);

        // Drain: 2..6 in order, memory untouched by the rejected write
        a_we = 0; a_re = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drain_rd%0d", i), a_rd, 2 + i);
            chk($sformatf("drain_rv%0d", i), a_rv, 1);
            chk($sformatf("drain_cnt%0d", i), a_cnt, 4 - i);
        end
        chk("drain_empty", a_empty, 1);
        a_re = 0;
        tick();
        chk("idle_rv", a_rv, 0);  chk("idle_rd_hold", a_rd, 6);

        // Empty, read+write together: push only, underflow
        a_we = 1; a_wd = 8'hAB; a_re = 1;
        tick();
        chk("eboth_un", a_un, 1);   chk("eboth_cnt", a_cnt, 1);
        chk("eboth_rv", a_rv, 0);   chk("eboth_rd_hold", a_rd, 6);
        chk("eboth_empty", a_empty, 0);
        a_we = 0; a_re = 1;
        tick();
        chk("eboth_read_rd", a_rd, 8'hAB);  chk("eboth_read_rv", a_rv, 1);
        chk("eboth_read_cnt", a_cnt, 0);    chk("ov_sticky", a_ov, 1);
        a_re = 0;

        // ---------------- A: wrap with 2 resident ----------------
        a_we = 1; a_wd = 8'd10; tick();
        a_wd = 8'd11; tick();
        chk("wrapA_pre_cnt", a_cnt, 2);
        a_re = 1;
        for (int i = 0; i < 20; i++) begin
            a_wd = 8'(12 + i);
            tick();
            chk($sformatf("wrapA_rd%0d", i), a_rd, 10 + i);
            chk($sformatf("wrapA_rv%0d", i), a_rv, 1);
            chk($sformatf("wrapA_cnt%0d", i), a_cnt, 2);
        end
        a_we = 0;
        tick(); chk("wrapA_tail0", a_rd, 30);
        tick(); chk("wrapA_tail1", a_rd, 31);
        chk("wrapA_empty", a_empty, 1);
        a_re = 0;

        // ---------------- B: FWFT ----------------
        b_we = 1; b_wd = 8'h11;
        tick();
        b_we = 0;
        chk("fwft_rd", b_rd, 8'h11);  chk("fwft_rv", b_rv, 1);
        chk("fwft_cnt", b_cnt, 1);
        tick();
        chk("fwft_hold_rd", b_rd, 8'h11);  chk("fwft_hold_rv", b_rv, 1);
        // count 1, pop and push together: new word becomes head
        b_we = 1; b_wd = 8'h12; b_re = 1;
        tick();
        chk("fwft_swap_rd", b_rd, 8'h12);  chk("fwft_swap_cnt", b_cnt, 1);
        b_we = 0;
        tick();
        chk("fwft_pop_rv", b_rv, 0);  chk("fwft_pop_empty", b_empty, 1);
        chk("fwft_pop_cnt", b_cnt, 0);
        // empty, both: push only, underflow, word shows as head
        b_we = 1; b_wd = 8'h13; b_re = 1;
        tick();
        chk("fwft_eboth_un", b_un, 1);  chk("fwft_eboth_rd", b_rd, 8'h13);
        chk("fwft_eboth_rv", b_rv, 1);
        b_we = 0;
        tick();
        chk("fwft_eboth_pop_rv", b_rv, 0);
        b_re = 0;

        // B wrap, 2 resident
        b_we = 1; b_wd = 8'd20; tick();
        chk("wrapB_head0", b_rd, 20);
        b_wd = 8'd21; tick();
        chk("wrapB_head1", b_rd, 20);
        b_re = 1;
        for (int i = 0; i < 20; i++) begin
            b_wd = 8'(22 + i);
            tick();
            chk($sformatf("wrapB_rd%0d", i), b_rd, 21 + i);
            chk($sformatf("wrapB_cnt%0d", i), b_cnt, 2);
        end
        b_we = 0;
        tick(); chk("wrapB_tail", b_rd, 41);
        tick(); chk("wrapB_empty_rv", b_rv, 0);
        b_re = 0;

        // B full with both asserted
        b_we = 1;
        for (int i = 0; i < 4; i++) begin
            b_wd = 8'(50 + i);
            tick();
        end
        chk("fwft_full", b_full, 1);  chk("fwft_af", b_af, 1);
        chk("fwft_full_head", b_rd, 50);
        b_wd = 8'd54; b_re = 1;
        tick();
        chk("fwft_fboth_cnt", b_cnt, 4);  chk("fwft_fboth_ov", b_ov, 0);
        chk("fwft_fboth_rd", b_rd, 51);
        b_we = 0; b_re = 0;

        // ---------------- reset mid-stream ----------------
        a_we = 1; a_wd = 8'd70; tick();
        a_wd = 8'd71; tick();
        chk("pre_rst_cnt", a_cnt, 2);
        reset = 1;
        tick();
        reset = 0; a_we = 0;
        chk("mrst_a_cnt", a_cnt, 0);      chk("mrst_a_empty", a_empty, 1);
        chk("mrst_a_ov", a_ov, 0);        chk("mrst_a_un", a_un, 0);
        chk("mrst_a_ae", a_ae, 1);        chk("mrst_a_af", a_af, 0);
        chk("mrst_a_rd", a_rd, 0);        chk("mrst_a_rv", a_rv, 0);
        chk("mrst_b_cnt", b_cnt, 0);      chk("mrst_b_empty", b_empty, 1);
        chk("mrst_b_rv", b_rv, 0);        chk("mrst_b_un", b_un, 0);
        chk("mrst_b_full", b_full, 0);
        // Discarded contents: a read now underflows
        a_re = 1;
        tick();
        a_re = 0;
        chk("post_rst_un", a_un, 1);  chk("post_rst_rv", a_rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
